// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine with a per-block bypass mode.
// A 128-bit state is transformed COLS_PER_CYCLE columns at a time. Each
// transaction is tagged forward, inverse or bypass when it is accepted.
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    input  logic         in_inv,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);

    localparam int         NCOL_GROUPS = 4 / COLS_PER_CYCLE;
    // Step of the 2-bit column counter. A step of 4 wraps to 0.
    localparam logic [1:0] COL_STEP    = 2'(COLS_PER_CYCLE % 4);
    // First column of the last group, seen on the final compute cycle.
    localparam logic [1:0] LAST_COL    = 2'((NCOL_GROUPS - 1) * COLS_PER_CYCLE);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [1:0]   col_cnt;
    logic [0:127] src_q;
    logic         inv_q;
    logic [0:127] res_q;
    logic [0:127] res_next;
    logic         accept;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the circulant matrix. The row-0 coefficients are
    // {02,03,01,01} forward and {0e,0b,0d,09} inverse; every other row is
    // the same list rotated right by the row number.
    function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
        logic [7:0]  a;
        logic [7:0]  x2;
        logic [7:0]  x4;
        logic [7:0]  x8;
        logic [7:0]  k0 [4];
        logic [7:0]  k1 [4];
        logic [7:0]  k2 [4];
        logic [7:0]  k3 [4];
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            a  = col[31 - 8*i -: 8];
            x2 = xtime(a);
            x4 = xtime(x2);
            x8 = xtime(x4);
            k0[i] = inv ? (x8 ^ x4 ^ x2) : x2;
            k1[i] = inv ? (x8 ^ x2 ^ a)  : (x2 ^ a);
            k2[i] = inv ? (x8 ^ x4 ^ a)  : a;
            k3[i] = inv ? (x8 ^ a)       : a;
        end
        for (int r = 0; r < 4; r++) begin
            b[31 - 8*r -: 8] = k0[r] ^ k1[(r + 1) % 4] ^ k2[(r + 2) % 4] ^ k3[(r + 3) % 4];
        end
        return b;
    endfunction

    // Handshake: a block moves across an interface on a rising edge where
    // valid and ready are both high. A producer holds valid and its payload
    // steady until that edge; ready may drop or rise without waiting for valid.
    // The input side is ready in IDLE, and in DONE whenever the result is
    // being taken in the same cycle, so blocks can run back to back.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign out_data = res_q;

    // Result register with the current column group replaced by its transform.
    always_comb begin
        logic [1:0] col;
        res_next = res_q;
        col      = '0;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            col = col_cnt + 2'(j);
            res_next[32*col +: 32] = mix_column(src_q[32*col +: 32], inv_q);
        end
    end

    // Control FSM, source and mode capture, and the result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            col_cnt   <= '0;
            src_q     <= '0;
            inv_q     <= 1'b0;
            res_q     <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            src_q   <= in_data;
            inv_q   <= in_inv;
            col_cnt <= '0;
            if (in_bypass) begin
                res_q     <= in_data;
                state     <= DONE;
                out_valid <= 1'b1;
            end else begin
                state     <= BUSY;
                out_valid <= 1'b0;
            end
        end else begin
            case (state)
                BUSY: begin
                    res_q   <= res_next;
                    col_cnt <= col_cnt + COL_STEP;
                    if (col_cnt == LAST_COL) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mix_columns_engine.md
Name: mix_columns_engine

Overview:
- Parametrised, handshaked MixColumns / InvMixColumns engine for the AES datapath, placed between ShiftRows and AddRoundKey in both the encrypt and decrypt round pipelines.
- Processes one 128-bit state per transaction over 4/COLS_PER_CYCLE compute cycles, so area and throughput trade off per instance.
- Each transaction is tagged at accept time as forward, inverse or bypass. Bypass serves the final AES round, which has no MixColumns.

Parameters:
- COLS_PER_CYCLE, 4, columns transformed per compute cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- NCOL_GROUPS, 4/COLS_PER_CYCLE, derived localparam, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  input block available.
- in_ready  output  1  engine can accept a block this cycle.
- in_data  input  [0:127]  state. Byte k = in_data[8k:8k+7]; column c = bytes 4c..4c+3; row r = byte 4c+r.
- in_inv  input  1  1 selects InvMixColumns. Sampled only on accept.
- in_bypass  input  1  1 passes the state through unchanged. Overrides in_inv. Sampled only on accept.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  [0:127]  result, same byte ordering as in_data.
- busy  output  1  high in the BUSY or DONE state.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, out_valid=0, out_data=0, column counter=0, source register=0, busy=0. in_ready=1 in the first cycle after release. A block in flight when reset asserts is discarded; no partial result is ever presented.
- Accept when in_valid and in_ready are both high at a rising edge. At that edge, in_data, in_inv and in_bypass are captured into source and mode registers.
- Forward transform per column (a0..a3 → b0..b3):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- Inverse transform uses the same circulant structure with coefficients 0e, 0b, 0d, 09 (b0 = 0e·a0^0b·a1^0d·a2^09·a3, rotated for each row).
- Field arithmetic is GF(2^8) with polynomial 0x11B. xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0). 3x = xtime(x)^x. 09/0b/0d/0e are built from xtime chains. No tables.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. Accept with bypass=0 → BUSY, col_cnt=0. Accept with bypass=1 → result register loaded with in_data, go to DONE.
  - BUSY: in_ready=0. Each cycle, columns col_cnt..col_cnt+COLS_PER_CYCLE-1 of the source are transformed and written into the same positions of the result register. col_cnt += COLS_PER_CYCLE. On the cycle that writes the last group, go to DONE and set out_valid=1.
  - DONE: out_valid=1 and in_ready=out_ready (combinational pass-through).
    - out_ready=1 with an accept: start the new block exactly as from IDLE, with no bubble.
    - out_ready=1 with no accept: go to IDLE, out_valid=0.
    - out_ready=0: hold.
- Latency, from the accept edge to the first edge at which out_valid=1: NCOL_GROUPS+1 edges transformed, 1 edge bypass.
- Throughput: one block per NCOL_GROUPS+1 cycles when out_ready is held high.
- out_data and out_valid are registered and stay stable while out_valid=1 and out_ready=0. Input changes during BUSY or DONE have no effect on the block in flight.
- out_data is updated only by writes to the result register. It holds the last result after the handshake; downstream ignores it while out_valid=0.
- col_cnt is 2 bits and wraps to 0 on entry to DONE. Unused columns are never read out of range.

Test Plan:
- FIPS-197 forward, all COLS_PER_CYCLE values. Columns db135345, f20a225c, 01010101, c6c6c6c6 (with inv=0) → out 8e4da1bc 9fdc589d 01010101 c6c6c6c6. out_valid rises after 2, 3 or 5 edges for COLS_PER_CYCLE 4, 2 or 1.
- Inverse: in = 8e4da1bc 9fdc589d d5d5d7d6 4d7ebdf8 with inv=1 → out db135345 f20a225c d4d4d4d5 2d26314c.
- Bypass: in_bypass=1 and in_inv=1 with arbitrary data → out_data equals in_data after 1 edge.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_data and out_valid are stable and in_ready=0. Raise out_ready with in_valid=1 → new block accepted the same edge, no idle cycle.
- Back-to-back random: 1000 random blocks with random inv/bypass and random out_ready → output order and values match the software model; no drops or duplicates.
- Reset mid-operation: assert rst=0 during BUSY (COLS_PER_CYCLE=1, col_cnt=2) → out_valid=0, out_data=0 and busy=0 immediately. After release, in_ready=1 and the next block produces the correct result.
